// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, ALU op-class and sequencer state constants
//
// Purpose: constants shared between the multi-cycle sequencer and the
//          datapath decode logic, plus a helper that classifies a latched opcode.
// Ports:   none (package)
package proc_pkg;

    localparam logic [4:0] OP_AR   = 5'b00000;
    localparam logic [4:0] OP_T    = 5'b00001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [3:0] ALUOP_ARITH = 4'b0010;
    localparam logic [3:0] ALUOP_PASS  = 4'b0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    typedef enum logic [1:0] {
        INSTR_AR,
        INSTR_T,
        INSTR_HALT,
        INSTR_ILLEGAL
    } instr_class_e;

    function automatic instr_class_e classify_opcode(input logic [4:0] op);
        instr_class_e cls;
        case (op)
            OP_AR:   cls = INSTR_AR;
            OP_T:    cls = INSTR_T;
            OP_HALT: cls = INSTR_HALT;
            default: cls = INSTR_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// rtl/seq_timeout_counter.sv - clearable up-counter with terminal flag for fetch timeout
//
// Purpose: counts cycles spent waiting for an instruction-memory ack.
// Ports:
//   CLK     in  clock, rising edge
//   RESET   in  synchronous active-high reset
//   clr     in  return count to zero (takes priority over inc)
//   inc     in  one more cycle waited without ack
//   expire  out this waiting cycle is the LIMIT-th one
module seq_timeout_counter #(
    parameter int LIMIT = 15,
    parameter int W     = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // count holds the number of earlier unanswered cycles, so the current
    // cycle is the LIMIT-th one when count equals LIMIT-1.
    assign expire = inc && (count == LAST);

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            count <= '0;
        end else if (inc && !expire) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/execute/writeback control FSM
//
// Purpose: sequences instruction fetch over an ack handshake and drives the
//          PC, IR, ALU op class, register-file write and write-mux selects.
// Optional: define MULTICYCLE_SEQ_PERF_COUNTER_EN to add cycle_count and
//           retired_count performance counters.
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   run               level; start/continue execution
//   imem_ack, instr   instruction memory response; instr valid with ack
//   imem_req          fetch request, held until ack or timeout
//   ir_write          load IR (FETCH cycle with ack)
//   pc_write          advance PC (WB)
//   reg_write         register-file write enable (WB)
//   alu_op            op class to ALU control
//   sel_art_reg       write-register select: 0=instr[14:11], 1=instr[22:19]
//   sel_art_data      write-data select: 0=ALU result, 1=sext(instr[18:0])
//   busy              FSM in FETCH/DECODE/EXEC/WB
//   halted, fault     sticky status, cleared only by RESET
//   cycle_count       (optional) busy cycles
//   retired_count     (optional) WB cycles plus HALT entries
module multicycle_sequencer #(
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_W        = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [3:0]  alu_op,
    output logic        sel_art_reg,
    output logic        sel_art_data,
    output logic        busy,
    output logic        halted,
    output logic        fault
`ifdef MULTICYCLE_SEQ_PERF_COUNTER_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
`endif
);

    import proc_pkg::*;

    if (IMEM_TIMEOUT < 1 || IMEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_params
        $error("multicycle_sequencer: IMEM_TIMEOUT must be 1..255 and CNT_W >= 1");
    end

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [4:0] opcode_q;
    logic       fetch_wait;
    logic       fetch_expired;
    logic       fetch_done;
    logic       is_t_instr;

    // Only the opcode field is consumed here; operand fields go straight to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[26:0];

    assign fetch_done = (state_q == ST_FETCH) && imem_ack;
    assign fetch_wait = (state_q == ST_FETCH) && !imem_ack;
    assign is_t_instr = (classify_opcode(opcode_q) == INSTR_T);

    // Cleared outside FETCH so every fetch starts a fresh timeout window.
    seq_timeout_counter #(
        .LIMIT (IMEM_TIMEOUT),
        .W     (8)
    ) u_fetch_timeout (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr    (!fetch_wait),
        .inc    (fetch_wait),
        .expire (fetch_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Ack checked first: an ack in the terminal cycle still succeeds.
                if (imem_ack)           state_d = ST_DECODE;
                else if (fetch_expired) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                case (classify_opcode(opcode_q))
                    INSTR_AR:   state_d = ST_EXEC;
                    INSTR_T:    state_d = ST_WB;
                    INSTR_HALT: state_d = ST_HALT;
                    default:    state_d = ST_FAULT;
                endcase
            end
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            opcode_q <= 5'b00000;
        end else begin
            state_q <= state_d;
            if (fetch_done) opcode_q <= instr[31:27];
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_op       = ALUOP_PASS;
        sel_art_reg  = 1'b0;
        sel_art_data = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
            end
            ST_EXEC: begin
                alu_op = ALUOP_ARITH;
            end
            ST_WB: begin
                pc_write  = 1'b1;
                reg_write = 1'b1;
                if (is_t_instr) begin
                    sel_art_reg  = 1'b1;
                    sel_art_data = 1'b1;
                    alu_op       = ALUOP_PASS;
                end else begin
                    alu_op = ALUOP_ARITH;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted = (state_q == ST_HALT);
    assign fault  = (state_q == ST_FAULT);

`ifdef MULTICYCLE_SEQ_PERF_COUNTER_EN
    logic retire_event;
    assign retire_event = (state_q == ST_WB) ||
                          ((state_q == ST_DECODE) && (state_d == ST_HALT));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (busy)         cycle_count   <= cycle_count + CNT_W'(1);
            if (retire_event) retired_count <= retired_count + CNT_W'(1);
        end
    end
`endif

endmodule
